// File: rtl/dsram_pkg.sv
// Shared types and helpers for the data-SRAM responder.
package dsram_pkg;

  typedef enum logic [1:0] {
    DSRAM_IDLE,
    DSRAM_WAIT,
    DSRAM_RESP
  } dsram_state_e;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) begin
        w[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/dsram_array.sv
// Word-wide data RAM, byte-lane writes, asynchronous read.
module dsram_array
  import dsram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= lane_merge(mem[addr], wdata, wstrb);
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: valid/ready requests, fixed-latency reads.
// Optional address checking with DSRAM_ERR_CHECK_EN.
module dsram_responder
  import dsram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW =
    (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

  dsram_state_e  state;
  logic [CW-1:0] cnt;
  logic [31:0]   off;
  logic [31:0]   ram_rdata;
  logic [31:0]   rdata_q;
  logic [AW-1:0] idx;
  logic          accept;
  logic          is_rd;
  logic          is_wr;
  logic          err;

  assign off = req_addr - BASE_ADDR;
  assign idx = off[AW+1:2];

`ifdef DSRAM_ERR_CHECK_EN
  logic err_q;

  // Below-base addresses wrap to huge offsets, so one compare covers both ends.
  assign err = (req_addr[1:0] != 2'b00) ||
               ({1'b0, off} >= (33'(DEPTH_WORDS) << 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (is_rd) begin
      err_q <= err;
    end
  end

  assign resp_err = err_q;
`else
  logic unused_addr;

  assign err         = 1'b0;
  assign unused_addr = ^{off[31:AW+2], off[1:0]};
  assign resp_err    = 1'b0;
`endif

  assign req_ready = !reset &&
    ((state == DSRAM_IDLE) ||
     ((state == DSRAM_RESP) && resp_ready));

  assign accept     = req_valid && req_ready;
  assign is_wr      = accept && (req_we != WSTRB_NONE) && !err;
  assign is_rd      = accept && (req_we == WSTRB_NONE);
  assign resp_valid = (state == DSRAM_RESP);
  assign resp_rdata = rdata_q;

  dsram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (is_wr),
    .wstrb(req_we),
    .addr (idx),
    .wdata(req_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DSRAM_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        DSRAM_IDLE, DSRAM_RESP: begin
          // is_rd in RESP implies the current response is taken.
          if (is_rd) begin
            rdata_q <= err ? '0 : ram_rdata;
            cnt     <= CNT_INIT;
            state   <= (LATENCY == 1) ? DSRAM_RESP
                                      : DSRAM_WAIT;
          end else if ((state == DSRAM_IDLE) || resp_ready) begin
            state <= DSRAM_IDLE;
          end
        end
        DSRAM_WAIT: begin
          if (cnt == '0) begin
            state <= DSRAM_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= DSRAM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Directed self-checking bench for dsram_responder.
module tb_dsram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [3:0]  req_we;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        l1_req_valid, l1_req_ready, l1_resp_valid, l1_resp_err;
  logic [3:0]  l1_req_we;
  logic [31:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  dsram_responder #(.LATENCY(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  dsram_responder #(.LATENCY(1)) u_dut_l1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (l1_req_valid),
    .req_ready (l1_req_ready),
    .req_we    (l1_req_we),
    .req_addr  (l1_req_addr),
    .req_wdata (l1_req_wdata),
    .resp_valid(l1_resp_valid),
    .resp_ready(1'b1),
    .resp_rdata(l1_resp_rdata),
    .resp_err  (l1_resp_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0]  we,
                       input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_we    = 4'h0;
  endtask

  task automatic write(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0]  we);
    drive(we, a, d);
    tick();
    idle_req();
  endtask

  task automatic read_check(input logic [31:0] a,
                            input logic [31:0] exp,
                            input string tag);
    drive(4'h0, a, 32'h0);
    tick();
    idle_req();
    tick();
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    tick();
  endtask

  initial begin
    idle_req();
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;
    l1_req_valid = 1'b0;
    l1_req_we    = 4'h0;
    l1_req_addr  = 32'h0;
    l1_req_wdata = 32'h0;

    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);

    // Reset while a read sits in WAIT.
    drive(4'h0, 32'h40, 32'h0);
    tick();
    idle_req();
    check("wait_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_valid", 32'(resp_valid), 32'd0);
      check("rst_hold_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_valid", 32'(resp_valid), 32'd0);
    end

    // Full write, then read with latency 2.
    write(32'h40, 32'hDEAD_BEEF, 4'hF);
    drive(4'h0, 32'h40, 32'h0);
    tick();
    idle_req();
    check("lat_wait_ready", 32'(req_ready), 32'd0);
    check("lat_wait_valid", 32'(resp_valid), 32'd0);
    tick();
    check("lat_valid", 32'(resp_valid), 32'd1);
    check("lat_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("lat_err", 32'(resp_err), 32'd0);
    tick();
    check("lat_done_valid", 32'(resp_valid), 32'd0);
    check("lat_idle_ready", 32'(req_ready), 32'd1);

    // Partial store.
    write(32'h80, 32'h1122_3344, 4'hF);
    write(32'h80, 32'hAABB_CCDD, 4'b0101);
    read_check(32'h80, 32'h11BB_33DD, "partial");

    // Backpressure, then release with a back-to-back read.
    resp_ready = 1'b0;
    drive(4'h0, 32'h40, 32'h0);
    tick();
    idle_req();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    drive(4'h0, 32'h80, 32'h0);
    #1;
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    tick();
    idle_req();
    check("b2b_wait_valid", 32'(resp_valid), 32'd0);
    tick();
    check("b2b_valid", 32'(resp_valid), 32'd1);
    check("b2b_rdata", resp_rdata, 32'h11BB_33DD);
    tick();

    // Write accepted while the response completes.
    drive(4'h0, 32'h40, 32'h0);
    tick();
    idle_req();
    tick();
    drive(4'b0011, 32'h40, 32'h0000_1234);
    tick();
    idle_req();
    check("resp_wr_valid", 32'(resp_valid), 32'd0);
    check("resp_wr_ready", 32'(req_ready), 32'd1);
    read_check(32'h40, 32'hDEAD_1234, "resp_wr");

    write(32'h0, 32'h0BAD_F00D, 4'hF);
`ifdef DSRAM_ERR_CHECK_EN
    drive(4'h0, 32'h1002, 32'h0);
    tick();
    idle_req();
    tick();
    check("err_valid", 32'(resp_valid), 32'd1);
    check("err_flag", 32'(resp_err), 32'd1);
    check("err_rdata", resp_rdata, 32'h0);
    tick();
    write(32'h1000, 32'hFFFF_FFFF, 4'hF);
    read_check(32'h0, 32'h0BAD_F00D, "oor_wr");
`else
    read_check(32'h1002, 32'h0BAD_F00D, "wrap");
`endif

    // Latency 1: back-to-back reads, one response per cycle.
    l1_req_valid = 1'b1;
    l1_req_we    = 4'hF;
    for (int i = 0; i < 4; i++) begin
      l1_req_addr  = 32'(4 * i);
      l1_req_wdata = 32'hC0DE_0000 + 32'(i);
      tick();
    end
    l1_req_we = 4'h0;
    for (int i = 0; i < 4; i++) begin
      l1_req_addr = 32'(4 * i);
      #1;
      check("l1_ready", 32'(l1_req_ready), 32'd1);
      tick();
      check("l1_valid", 32'(l1_resp_valid), 32'd1);
      check("l1_rdata", l1_resp_rdata, 32'hC0DE_0000 + 32'(i));
    end
    l1_req_valid = 1'b0;
    tick();
    check("l1_done_valid", 32'(l1_resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dsram_responder.md
# dsram_responder

Data-SRAM responder for the LA32R pipeline: the memory side of the data-request interface that the decode/execute stages drive (enable, 4-bit byte write strobe, 32-bit address). It accepts one request at a time over a valid/ready handshake and commits stores with byte granularity. It returns load data after a configurable fixed latency, with the response held until the memory stage takes it. The block sits between the EXE/MEM pipeline registers and the on-chip data RAM and replaces the ideal zero-wait SRAM model.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; must be a power of 2, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- LATENCY, 2: cycles from read acceptance to resp_valid; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept the request this cycle.
- req_we  in  4  byte-lane write strobes; 4'b0000 means read.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; lane i is bits [8i+7:8i].
- resp_valid  out  1  read response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load data.
- resp_err  out  1  the read was misaligned or out of range.

## Operation
- A request is accepted when req_valid and req_ready are both high.
- Word index = (req_addr - BASE_ADDR) >> 2, truncated to clog2(DEPTH_WORDS) bits.
- Three states: IDLE, WAIT, RESP.
  - IDLE: req_ready is high.
    - An accepted write (any req_we bit set) commits in the acceptance cycle. It produces no response and the state stays IDLE.
    - An accepted read samples the RAM word into rdata_q and captures err into err_q.
    - The read goes to RESP if LATENCY==1. Otherwise it goes to WAIT with cnt = LATENCY-2.
  - WAIT: req_ready is low. cnt decrements each cycle. When cnt==0, the state goes to RESP.
  - RESP: resp_valid is high; resp_rdata and resp_err are stable.
    - When resp_ready is high, the response completes.
    - req_ready = resp_ready in this state, which allows back-to-back requests.
    - A read accepted in the same cycle follows the IDLE rules for the next state.
    - A write accepted in the same cycle commits, and the state goes to IDLE.
    - If nothing is accepted, the state goes to IDLE.
- Store: only lanes with req_we[i]=1 are updated; other lanes keep their value.
- Write-then-read to the same word in consecutive accepted requests must return the new data. No bypass is needed because the RAM is written at acceptance.
- Reads never alter RAM.
- Reset, including mid-WAIT or mid-RESP:
  - The state goes to IDLE, cnt=0, and the pending read is discarded.
  - All outputs reset as follows: resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 once reset deasserts. req_ready is 0 while reset is high.
  - RAM contents are not reset.

## Timing
- Read accepted at cycle T: resp_valid rises at T+LATENCY and is held until the handshake.
- Peak read throughput: 1 per LATENCY cycles with resp_ready tied high.
- Write: accepted in 1 cycle when in IDLE, or in RESP with resp_ready high. RAM is updated at that clock edge.
- All outputs are registered or decoded from the state register only. There is no combinational path from req_* to resp_*. req_ready depends combinationally on resp_ready only in RESP.

## Configuration
- DSRAM_ERR_CHECK_EN defined:
  - The error flag err is set when req_addr[1:0]!=0, or when req_addr is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
  - An erroring read returns resp_rdata=0 and resp_err=1.
  - An erroring write is dropped and RAM is unchanged.
- DSRAM_ERR_CHECK_EN undefined:
  - req_addr[1:0] are ignored and the index wraps modulo DEPTH_WORDS.
  - resp_err is tied 0 and the error logic is absent.

## Structure
- Shared package dsram_pkg:
  - state enum DSRAM_IDLE/DSRAM_WAIT/DSRAM_RESP;
  - constant WSTRB_NONE = 4'b0000;
  - function for byte-lane merge (old word, wdata, strobe).
- Sub-module dsram_array: word-wide RAM with 4 byte-write enables and an asynchronous read port.
- The FSM, latency counter, error check and response register live in dsram_responder.

## Test plan
- Reset held 3 cycles during WAIT of a read to 0x40 -> resp_valid never rises; req_ready=1 the cycle after reset deasserts; no response from the earlier read appears.
- Write 0x40 data 0xDEADBEEF we=4'hF, then read 0x40, LATENCY=2, resp_ready=1:
  - resp_valid exactly 2 cycles after read acceptance, rdata=0xDEADBEEF;
  - req_ready low in the single WAIT cycle.
- Partial store: word 0x80 = 0x11223344, write we=4'b0101 data 0xAABBCCDD, read -> 0x11BB33DD.
- Backpressure: read 0x40 with resp_ready=0 for 5 cycles:
  - resp_valid and rdata held stable, req_ready=0;
  - resp_ready=1 together with a read of 0x80 -> both handshake in the same cycle; next response = word 0x80.
- With DSRAM_ERR_CHECK_EN, DEPTH_WORDS=1024:
  - read 0x1002 -> resp_err=1, rdata=0;
  - write 0x1000 -> RAM unchanged; a following read of 0x0 returns its prior value.
- LATENCY=1, resp_ready=1, 4 reads at 0x0/0x4/0x8/0xC -> one response per cycle in order, no bubbles.
